// File: rtl/scan_sequencer.sv
// scan_sequencer
//   Walks a rows x cols grid in row-major order and emits one (row, col) index
//   pair per accepted valid/ready transfer. Owns the start/done protocol for the
//   downstream datapath counters and register file.
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-low reset
//   start  in   request a new scan (sampled only in IDLE)
//   rows   in   row count, WORD_LENGTH+1 bits, latched on accepted start
//   cols   in   column count, WORD_LENGTH+1 bits, latched on accepted start
//   ready  in   downstream accepts the current pair
//   valid  out  row/col/last are meaningful
//   row    out  current row index
//   col    out  current column index
//   last   out  current pair is (rows-1, cols-1)
//   busy   out  scan in progress (RUN or DONE)
//   done   out  one-cycle pulse after the final transfer
//   err    out  one-cycle pulse on start with a zero dimension
module scan_sequencer #(
   parameter int unsigned WORD_LENGTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [WORD_LENGTH:0]   rows,
   input  logic [WORD_LENGTH:0]   cols,
   input  logic                   ready,
   output logic                   valid,
   output logic [WORD_LENGTH-1:0] row,
   output logic [WORD_LENGTH-1:0] col,
   output logic                   last,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   localparam int unsigned DW = WORD_LENGTH + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t                 state, state_n;
   logic [DW-1:0]          rows_q, cols_q, rows_n, cols_n;
   logic [WORD_LENGTH-1:0] row_n, col_n;
   logic                   valid_n, last_n, busy_n, done_n, err_n;

   // Indices are zero-extended so that a dimension of 2^WORD_LENGTH compares
   // correctly against a maximum index of 2^WORD_LENGTH-1.
   logic [DW-1:0] row_x, col_x, rows_m1, cols_m1;
   logic          row_end, col_end;

   assign row_x   = {1'b0, row};
   assign col_x   = {1'b0, col};
   assign rows_m1 = rows_q - DW'(1);
   assign cols_m1 = cols_q - DW'(1);
   assign row_end = (row_x == rows_m1);
   assign col_end = (col_x == cols_m1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= S_IDLE;
         rows_q <= '0;
         cols_q <= '0;
         row    <= '0;
         col    <= '0;
         valid  <= 1'b0;
         last   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
      end else begin
         state  <= state_n;
         rows_q <= rows_n;
         cols_q <= cols_n;
         row    <= row_n;
         col    <= col_n;
         valid  <= valid_n;
         last   <= last_n;
         busy   <= busy_n;
         done   <= done_n;
         err    <= err_n;
      end
   end

   // All outputs are registered, so last is computed for the pair that will be
   // presented next rather than decoded from the current one.
   always_comb begin
      state_n = state;
      rows_n  = rows_q;
      cols_n  = cols_q;
      row_n   = row;
      col_n   = col;
      valid_n = valid;
      last_n  = last;
      busy_n  = busy;
      done_n  = 1'b0;
      err_n   = 1'b0;

      case (state)
         S_IDLE: begin
            valid_n = 1'b0;
            last_n  = 1'b0;
            busy_n  = 1'b0;
            if (start) begin
               if ((rows == '0) || (cols == '0)) begin
                  err_n = 1'b1;
               end else begin
                  rows_n  = rows;
                  cols_n  = cols;
                  row_n   = '0;
                  col_n   = '0;
                  valid_n = 1'b1;
                  busy_n  = 1'b1;
                  last_n  = (rows == DW'(1)) && (cols == DW'(1));
                  state_n = S_RUN;
               end
            end
         end

         S_RUN: begin
            if (valid && ready) begin
               if (!col_end) begin
                  col_n  = col + WORD_LENGTH'(1);
                  last_n = row_end && ((col_x + DW'(1)) == cols_m1);
               end else if (!row_end) begin
                  col_n  = '0;
                  row_n  = row + WORD_LENGTH'(1);
                  last_n = ((row_x + DW'(1)) == rows_m1) && (cols_q == DW'(1));
               end else begin
                  row_n   = '0;
                  col_n   = '0;
                  valid_n = 1'b0;
                  last_n  = 1'b0;
                  done_n  = 1'b1;
                  state_n = S_DONE;
               end
            end
         end

         S_DONE: begin
            busy_n  = 1'b0;
            state_n = S_IDLE;
         end

         default: begin
            valid_n = 1'b0;
            last_n  = 1'b0;
            busy_n  = 1'b0;
            state_n = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_scan_sequencer.sv
module tb_scan_sequencer;

   localparam int WL = 8;

   localparam int K_PAIR = 0;
   localparam int K_DONE = 1;
   localparam int K_ERR  = 2;

   typedef struct {
      int kind;
      int r;
      int c;
      bit l;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [WL:0]   rows_i = '0;
   logic [WL:0]   cols_i = '0;
   logic          ready = 1'b0;
   logic          valid;
   logic [WL-1:0] row;
   logic [WL-1:0] col;
   logic          last;
   logic          busy;
   logic          done;
   logic          err;

   int checks = 0;
   int failures = 0;
   exp_t exp_q[$];

   scan_sequencer #(.WORD_LENGTH(WL)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .rows  (rows_i),
      .cols  (cols_i),
      .ready (ready),
      .valid (valid),
      .row   (row),
      .col   (col),
      .last  (last),
      .busy  (busy),
      .done  (done),
      .err   (err)
   );

   always #5 clk = ~clk;

   initial begin
      repeat (60000) @(posedge clk);
      $display("FAIL watchdog: cycles=60000 required=finish earlier");
      $fatal(1);
   end

   // Monitor: compares DUT outputs against the expected-event queue.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         if (valid) begin
            checks++;
            if (!busy) begin
               failures++;
               $display("FAIL busy_in_run: busy=%0b required=1", busy);
            end
         end else begin
            checks++;
            if (last) begin
               failures++;
               $display("FAIL last_without_valid: last=%0b required=0", last);
            end
         end
         if (valid && ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_pair: got (%0d,%0d) required=none", row, col);
            end else begin
               e = exp_q.pop_front();
               if (e.kind != K_PAIR || int'(row) != e.r || int'(col) != e.c || last != e.l) begin
                  failures++;
                  $display("FAIL pair: got kind=%0d (%0d,%0d) last=%0b required kind=%0d (%0d,%0d) last=%0b",
                           K_PAIR, row, col, last, e.kind, e.r, e.c, e.l);
               end
            end
         end else if (valid && !ready && exp_q.size() != 0) begin
            if (exp_q[0].kind == K_PAIR) begin
               checks++;
               if (int'(row) != exp_q[0].r || int'(col) != exp_q[0].c || last != exp_q[0].l) begin
                  failures++;
                  $display("FAIL hold: got (%0d,%0d) last=%0b required (%0d,%0d) last=%0b",
                           row, col, last, exp_q[0].r, exp_q[0].c, exp_q[0].l);
               end
            end
         end
         if (done) begin
            checks++;
            if (exp_q.size() == 0 || exp_q[0].kind != K_DONE || !busy || valid) begin
               failures++;
               $display("FAIL done_pulse: done=1 busy=%0b valid=%0b qsize=%0d required expected done with busy=1 valid=0",
                        busy, valid, exp_q.size());
            end
            if (exp_q.size() != 0 && exp_q[0].kind == K_DONE) void'(exp_q.pop_front());
         end
         if (err) begin
            checks++;
            if (exp_q.size() == 0 || exp_q[0].kind != K_ERR || busy || valid || done) begin
               failures++;
               $display("FAIL err_pulse: err=1 busy=%0b valid=%0b done=%0b qsize=%0d required expected err with others 0",
                        busy, valid, done, exp_q.size());
            end
            if (exp_q.size() != 0 && exp_q[0].kind == K_ERR) void'(exp_q.pop_front());
         end
      end
   end

   // Reference model: the full row-major pair list followed by one done.
   task automatic push_scan(input int r, input int c);
      for (int i = 0; i < r; i++)
         for (int k = 0; k < c; k++)
            exp_q.push_back('{K_PAIR, i, k, (i == r - 1) && (k == c - 1)});
      exp_q.push_back('{K_DONE, 0, 0, 1'b0});
   endtask

   // stall_pct: random ready=0 percentage; stall_at: transfer index at which
   // ready is held low for 3 cycles (-1 = none); mid: hammer start during RUN.
   task automatic do_scan(input int r, input int c, input int stall_pct,
                          input int stall_at, input bit mid);
      int n, stalls, xfers, held;
      bit seen;
      n = r * c;
      stalls = 0; xfers = 0; held = 0; seen = 1'b0;
      push_scan(r, c);
      @(posedge clk); #1;
      start = 1'b1; rows_i = 9'(r); cols_i = 9'(c); ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (!valid || row != 0 || col != 0 || !busy) begin
         failures++;
         $display("FAIL start_latency: valid=%0b busy=%0b (%0d,%0d) required valid=1 busy=1 (0,0)",
                  valid, busy, row, col);
      end
      for (int j = 1; j <= n * 4 + 20 && !seen; j++) begin
         if (stall_at >= 0) begin
            ready = !(xfers == stall_at && held < 3);
            if (!ready) held++;
         end else begin
            ready = ($urandom_range(99) >= stall_pct);
         end
         if (mid) begin
            start = 1'b1;
            rows_i = 9'($urandom_range(511));
            cols_i = 9'($urandom_range(511));
         end
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            checks++;
            if (j != n + 1 + stalls) begin
               failures++;
               $display("FAIL done_timing: cycle=%0d required=%0d (%0dx%0d stalls=%0d)",
                        j, n + 1 + stalls, r, c, stalls);
            end
         end else if (valid && !ready) begin
            stalls++;
         end else if (valid && ready) begin
            xfers++;
         end
         if (!seen) begin
            @(posedge clk); #1;
         end
      end
      start = 1'b0;
      ready = 1'b1;
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL done_timeout: done=0 required=1 (%0dx%0d)", r, c);
      end else begin
         if (stall_at >= 0) begin
            checks++;
            if (stalls != 3) begin
               failures++;
               $display("FAIL stall_count: stalls=%0d required=3", stalls);
            end
         end
         @(posedge clk); #1;
         checks++;
         if (busy || done || valid) begin
            failures++;
            $display("FAIL post_done_idle: busy=%0b done=%0b valid=%0b required all 0", busy, done, valid);
         end
      end
   endtask

   task automatic do_err(input int r, input int c);
      exp_q.push_back('{K_ERR, 0, 0, 1'b0});
      @(posedge clk); #1;
      start = 1'b1; rows_i = 9'(r); cols_i = 9'(c);
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (!err || valid || busy || done) begin
         failures++;
         $display("FAIL err_cycle: err=%0b valid=%0b busy=%0b done=%0b required err=1 others 0",
                  err, valid, busy, done);
      end
      @(posedge clk); #1;
      checks++;
      if (err || valid || busy || done) begin
         failures++;
         $display("FAIL err_after: err=%0b valid=%0b busy=%0b done=%0b required all 0",
                  err, valid, busy, done);
      end
   endtask

   task automatic do_reset_mid_scan();
      for (int i = 0; i < 2; i++)
         for (int k = 0; k < 3; k++)
            if (!(i == 1 && k == 2)) exp_q.push_back('{K_PAIR, i, k, 1'b0});
      @(posedge clk); #1;
      start = 1'b1; rows_i = 9'd2; cols_i = 9'd3; ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (!valid || row != 1 || col != 2 || !last) begin
         failures++;
         $display("FAIL pre_reset_pos: valid=%0b (%0d,%0d) last=%0b required valid=1 (1,2) last=1",
                  valid, row, col, last);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (valid || row != 0 || col != 0 || last || busy || done || err) begin
         failures++;
         $display("FAIL async_reset: valid=%0b row=%0d col=%0d last=%0b busy=%0b done=%0b err=%0b required all 0",
                  valid, row, col, last, busy, done, err);
      end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (valid || busy || done) begin
         failures++;
         $display("FAIL post_reset_idle: valid=%0b busy=%0b done=%0b required all 0", valid, busy, done);
      end
   endtask

   initial begin
      #1;
      checks++;
      if (valid || row != 0 || col != 0 || last || busy || done || err) begin
         failures++;
         $display("FAIL reset_state: valid=%0b row=%0d col=%0d last=%0b busy=%0b done=%0b err=%0b required all 0",
                  valid, row, col, last, busy, done, err);
      end
      #20;
      rst = 1'b1;
      ready = 1'b1;

      do_scan(2, 3, 0, -1, 1'b0);
      do_scan(2, 2, 0, 1, 1'b0);
      do_err(0, 5);
      do_scan(1, 1, 0, -1, 1'b0);
      do_scan(3, 3, 0, -1, 1'b1);
      do_scan(1, 256, 0, -1, 1'b0);
      do_reset_mid_scan();
      do_scan(2, 3, 0, -1, 1'b0);
      do_err(7, 0);

      for (int t = 0; t < 40; t++) begin
         int sel;
         sel = $urandom_range(9);
         if (sel == 0) begin
            do_err($urandom_range(1) * $urandom_range(256), 0);
         end else if (sel == 1) begin
            do_scan($urandom_range(1, 2), 256, $urandom_range(30), -1, 1'($urandom_range(1)));
         end else begin
            do_scan($urandom_range(1, 7), $urandom_range(1, 7), $urandom_range(60), -1,
                    1'($urandom_range(1)));
         end
      end

      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL queue_drain: remaining=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/scan_sequencer.md
# scan_sequencer

Two-level index sequencer that walks a rows × cols grid in row-major order. It emits one (row, col) pair per accepted transfer on a valid/ready handshake. It is the control stage directly upstream of the datapath counters and register file: it owns the start/done protocol, and downstream consumers see only index pairs, a last flag and a done pulse.

## Interface
- WORD_LENGTH, 8, width of each emitted index; dimension inputs are WORD_LENGTH+1 bits wide so that 2^WORD_LENGTH is representable.

- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request a new scan; sampled only in IDLE.
- rows  in  WORD_LENGTH+1  row count; latched on accepted start.
- cols  in  WORD_LENGTH+1  column count; latched on accepted start.
- ready  in  1  downstream accepts the current pair.
- valid  out  1  row/col/last are meaningful.
- row  out  WORD_LENGTH  current row index.
- col  out  WORD_LENGTH  current column index.
- last  out  1  current pair is (rows-1, cols-1).
- busy  out  1  scan in progress (RUN or DONE).
- done  out  1  one-cycle pulse after the final transfer.
- err  out  1  one-cycle pulse: start with rows==0 or cols==0.

## Operation
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset state: IDLE. All outputs are 0, including row, col, valid, last, busy, done and err. Latched dimensions clear to 0.
- Transfer: a transfer occurs on a cycle where valid && ready.
- States are IDLE, RUN and DONE. All outputs are registered.
- IDLE:
  - start=1 with rows≠0 and cols≠0: latch rows/cols, row=0, col=0, go to RUN.
  - start=1 with either dimension zero: pulse err for one cycle and stay in IDLE. No valid, no done.
- RUN: valid=1 and busy=1. On a transfer:
  - col < cols-1: col+1.
  - col == cols-1 and row < rows-1: col=0, row+1.
  - col == cols-1 and row == rows-1: valid=0, go to DONE.
- Backpressure: with ready=0, row, col, valid and last hold unchanged.
- DONE: done=1 and busy=1 for exactly one cycle, valid=0, then go to IDLE.
- last: valid && row==rows-1 && col==cols-1, comparing against the latched dimensions.
- Width rules:
  - Compare at WORD_LENGTH+1 bits, with indices zero-extended.
  - rows or cols equal to 2^WORD_LENGTH is legal; the maximum index is 2^WORD_LENGTH-1 and never wraps.
- start outside IDLE is ignored. rows/cols changing during RUN has no effect.
- rows=1, cols=1: exactly one transfer, with last asserted on it.

## Timing
- Start latency: start accepted at edge t gives valid=1 with (0,0) from edge t+1.
- Throughput: with ready held high, one pair per cycle. rows*cols transfers occupy cycles t+1 … t+rows*cols.
- Completion: done is high in cycle t+rows*cols+1, and busy falls in the same cycle that done falls. The earliest next accepted start is at edge t+rows*cols+2.
- Stall cost: each cycle of ready=0 in RUN adds exactly one cycle to the schedule.
- err timing: err is high in the cycle following the rejected start.
- Reset mid-scan: rst low forces IDLE and all outputs to 0 immediately, independent of clk. No done is produced for the aborted scan. After rst deasserts, the first start is accepted normally.

## Test plan
- Reset: drive rst low during RUN at (1,2) -> all outputs 0 immediately, without waiting for a clock edge. After release, state is IDLE and no done is emitted.
- rows=2, cols=3, ready=1:
  - Sequence (0,0) (0,1) (0,2) (1,0) (1,1) (1,2) in consecutive cycles.
  - last only on (1,2).
  - done one cycle later; busy high from t+1 through the done cycle.
- Backpressure, rows=2, cols=2, ready=0 for 3 cycles while at (0,1) -> (0,1) holds for 4 cycles. Completion slips by exactly 3 cycles.
- start with rows=0, cols=5 -> err pulses one cycle; valid, busy and done stay 0. A following start with rows=1, cols=1 -> one transfer with last=1, then done.
- start re-asserted, and rows/cols changed, during RUN of a 3×3 scan -> ignored; exactly 9 transfers complete.
- WORD_LENGTH=8, rows=1, cols=256 -> col runs 0…255 without wrap; last on col=255; 256 transfers, then done.
